alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's 4-bit A/B-register ALU. It holds two WIDTH-bit operand registers and executes the same inverter-plus-arithmetic/logic function set in one cycle. It adds a multi-cycle shift-add multiply, a valid/ready issue handshake, registered status flags and a global clock enable. It sits between the datapath's operand bus and the writeback register.

---
 rtl/alu_seq.sv | 186 ++++++++++++++++++
 tb/tb_alu_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit A/B-register ALU with handshaked issue, one-cycle
// add/and/or with operand inversion, multi-cycle shift-add multiply.
// Ports: clk, rst_n (sync, active-low), en (global enable),
//   din/load_a/load_b (operand loads), f[4:0] (function), in_valid/in_ready
//   (issue), y/out_valid (result), zero/negative/carry/overflow (flags).
// Optional feature macro: ALU_FLAGS_EN builds the flag registers and logic;
//   when undefined the flag outputs are tied to 0.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             load_a,
  input  logic             load_b,
  input  logic [4:0]       f,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef ALU_FLAGS_EN
  // full-width product needed for the multiply carry flag
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic             r_out_valid;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;

  logic             w_issue;
  logic             w_mul_done;
  logic             w_wr;
  logic [WIDTH-1:0] w_a_op;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH-1:0] w_res_1c;
  logic [WIDTH-1:0] w_res;
  logic [PW-1:0]    w_acc_nxt;
`ifdef ALU_FLAGS_EN
  logic [WIDTH:0]   w_sum;
`else
  logic [WIDTH-1:0] w_sum;
`endif

  assign in_ready = en & (r_state == S_IDLE);
  assign w_issue  = in_valid & in_ready;

  assign w_a_op = f[3] ? ~r_a : r_a;
  assign w_b_op = f[2] ? ~r_b : r_b;

`ifdef ALU_FLAGS_EN
  assign w_sum = {1'b0, w_a_op} + {1'b0, w_b_op}
               + {{WIDTH{1'b0}}, f[0]};
`else
  assign w_sum = w_a_op + w_b_op
               + {{(WIDTH-1){1'b0}}, f[0]};
`endif

  assign w_logic  = f[0] ? (w_a_op | w_b_op) : (w_a_op & w_b_op);
  assign w_res_1c = f[1] ? w_sum[WIDTH-1:0] : w_logic;

  // last step folds its partial product straight into the result
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_done = en & (r_state == S_MUL)
                    & (r_cnt == CW'(WIDTH - 1));

  // issue needs IDLE, so the two writers never coincide
  assign w_wr  = (w_issue & ~f[4]) | w_mul_done;
  assign w_res = w_mul_done ? w_acc_nxt[WIDTH-1:0] : w_res_1c;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_issue && f[4]) w_state_nxt = S_MUL;
      S_MUL:  if (w_mul_done)      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      // result strobe lasts exactly one cycle, even across en=0
      r_out_valid <= 1'b0;
      if (en) begin
        r_state <= w_state_nxt;
        if (r_state == S_IDLE) begin
          if (load_a) r_a <= din;
          if (load_b) r_b <= din;
        end
        if (w_issue && f[4]) begin
          r_mcand  <= PW'(w_a_op);
          r_mplier <= w_b_op;
          r_acc    <= '0;
          r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= w_mul_done ? '0 : r_cnt + CW'(1);
        end
        if (w_wr) begin
          r_y         <= w_res;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign y         = r_y;
  assign out_valid = r_out_valid;

`ifdef ALU_FLAGS_EN
  logic r_zero;
  logic r_neg;
  logic r_carry;
  logic r_ovf;
  logic w_c;
  logic w_v;
  logic w_ovf_add;

  // signed overflow: like-signed operands, result sign differs
  assign w_ovf_add = (w_a_op[WIDTH-1] == w_b_op[WIDTH-1])
                   & (w_sum[WIDTH-1] != w_a_op[WIDTH-1]);

  assign w_c = w_mul_done ? (|w_acc_nxt[PW-1:WIDTH])
             : (f[1] & w_sum[WIDTH]);
  assign w_v = ~w_mul_done & f[1] & w_ovf_add;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (en && w_wr) begin
      r_zero  <= (w_res == '0);
      r_neg   <= w_res[WIDTH-1];
      r_carry <= w_c;
      r_ovf   <= w_v;
    end
  end

  assign zero     = r_zero;
  assign negative = r_neg;
  assign carry    = r_carry;
  assign overflow = r_ovf;
`else
  assign zero     = 1'b0;
  assign negative = 1'b0;
  assign carry    = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq, WIDTH=8.
// Flag expectations follow whether ALU_FLAGS_EN is defined.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] din;
  logic       load_a;
  logic       load_b;
  logic [4:0] f;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y;
  logic       out_valid;
  logic       zero;
  logic       negative;
  logic       carry;
  logic       overflow;

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] q[$];
  logic [7:0]  ma;
  logic [7:0]  mb;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .load_a(load_a), .load_b(load_b), .f(f),
    .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .zero(zero),
    .negative(negative), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [4:0] fv);
    logic [7:0] ap;
    logic [7:0] bp;
    logic [7:0] r;
    logic       c;
    logic       v;
    int         u;
    int         s;
    ap = fv[3] ? ~a : a;
    bp = fv[2] ? ~b : b;
    c  = 1'b0;
    v  = 1'b0;
    if (fv[4]) begin
      u = int'(ap) * int'(bp);
      r = u[7:0];
      c = (u > 255);
    end else if (fv[1]) begin
      u = int'(ap) + int'(bp) + int'(fv[0]);
      s = int'($signed(ap)) + int'($signed(bp)) + int'(fv[0]);
      r = u[7:0];
      c = (u > 255);
      v = (s > 127) || (s < -128);
    end else begin
      r = fv[0] ? (ap | bp) : (ap & bp);
    end
`ifdef ALU_FLAGS_EN
    return {r, (r == 8'h00), r[7], c, v};
`else
    return {r, 4'b0000};
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
      else chk("result", {y, zero, negative, carry, overflow},
               q.pop_front());
    end
  end

  task automatic ld(input logic la, input logic lb,
                    input logic [7:0] d);
    load_a = la;
    load_b = lb;
    din    = d;
    @(negedge clk);
    if (la) ma = d;
    if (lb) mb = d;
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  task automatic issue(input logic [4:0] fv, input logic la,
                       input logic lb, input logic [7:0] d,
                       input logic push);
    chk("in_ready_at_issue", in_ready, 1'b1);
    in_valid = 1'b1;
    f        = fv;
    load_a   = la;
    load_b   = lb;
    din      = d;
    if (push) q.push_back(model(ma, mb, fv));
    @(negedge clk);
    if (la) ma = d;
    if (lb) mb = d;
    in_valid = 1'b0;
    load_a   = 1'b0;
    load_b   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] rv;
    rst_n = 1'b0; en = 1'b1; din = '0; load_a = 0; load_b = 0;
    f = '0; in_valid = 1'b0; ma = '0; mb = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_y", y, 8'h00);
    chk("rst_flags", {zero, negative, carry, overflow}, 4'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // signed add overflow
    ld(1, 0, 8'h7F);
    ld(0, 1, 8'h01);
    issue(5'b00010, 0, 0, 0, 1);
    chk("add_out_valid", out_valid, 1'b1);
    @(negedge clk);
    chk("add_pulse_len", out_valid, 1'b0);

    // B - A both ways
    ld(1, 0, 8'h05);
    ld(0, 1, 8'h03);
    issue(5'b01011, 0, 0, 0, 1);
    ld(1, 0, 8'h03);
    ld(0, 1, 8'h05);
    issue(5'b01011, 0, 0, 0, 1);

    // multiply, load_a attempted mid-operation
    ld(1, 1, 8'h10);
    ld(0, 1, 8'h11);
    issue(5'b10000, 0, 0, 0, 1);
    n = 0;
    din = 8'hAA;
    while (!in_ready && n < 40) begin
      load_a = (n == 3);
      n++;
      @(negedge clk);
    end
    load_a = 1'b0;
    chk("mul_latency", n, 8);
    chk("mul_out_valid", out_valid, 1'b1);
    issue(5'b00010, 0, 0, 0, 1);

    // multiply with 3 stalled cycles
    issue(5'b10000, 0, 0, 0, 1);
    n = 0;
    while (!in_ready && n < 40) begin
      en = (n < 2) || (n >= 5);
      n++;
      @(negedge clk);
    end
    en = 1'b1;
    chk("mul_stall_latency", n, 11);
    chk("mul_stall_out_valid", out_valid, 1'b1);

    // back-to-back single-cycle ops with loads on issue edges
    issue(5'b00011, 0, 0, 0, 1);
    issue(5'b00001, 1, 0, 8'h81, 1);
    issue(5'b00110, 0, 1, 8'hF0, 1);
    issue(5'b01100, 1, 1, 8'h80, 1);
    issue(5'b00010, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      rv = $urandom;
      issue({1'b0, rv[3:0]}, rv[4], rv[5], rv[15:8], 1);
    end
    @(negedge clk);
    @(negedge clk);

    // reset in the middle of a multiply
    ld(1, 1, 8'hFF);
    issue(5'b10000, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_y", y, 8'h00);
    chk("midrst_flags", {zero, negative, carry, overflow}, 4'h0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    ma = '0;
    mb = '0;
    repeat (12) @(negedge clk);
    issue(5'b00001, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("sb_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
